sobel_window_buffer: RTL and testbench
======================================

SOBEL_WINDOW_BUFFER -- requirements
Module: sobel_window_buffer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, active pixels per line (range 3..2048).
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, lines per frame (range 3..2048).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port pix_in  input  16  streamed RGB565 pixel, raster order.
REQ-006 SHALL have port pix_valid  input  1  pix_in is accepted on this edge.
REQ-007 SHALL have port sof  input  1  start of frame, qualified by pix_valid; marks the pixel at (row 0, col 0).
REQ-008 SHALL have port window_out  output  144  3x3 RGB565 neighbourhood; element k occupies bits [16k+15:16k].
REQ-009 SHALL have port win_valid  output  1  window_out, win_col and win_row are valid this cycle.
REQ-010 SHALL have port win_col  output  clog2(IMG_WIDTH)  centre column of the window.
REQ-011 SHALL have port win_row  output  clog2(IMG_HEIGHT)  centre row of the window.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse, last pixel of the frame accepted.

Function
REQ-013 SHALL order window elements row-major: k=0..2 top row (left..right), 3..5 middle, 6..8 bottom; element 8 is the newest pixel. This matches the Sobel stage input order.
REQ-014 SHALL hold two line buffers of IMG_WIDTH x 16 bits (rows r-1, r-2), written at address col on every accepted pixel.
REQ-015 SHALL hold a 3x3 register array that shifts left by one column on every accepted pixel: new right column = {linebuf2[col], linebuf1[col], pix_in}.
REQ-016 SHALL keep col and row counters that advance only when pix_valid=1.
REQ-017 SHALL wrap col from IMG_WIDTH-1 to 0 and increment row; at (IMG_HEIGHT-1, IMG_WIDTH-1), col and row both return to 0.
REQ-018 SHALL treat a pixel with pix_valid=1 and sof=1 as (0,0) regardless of the counters, then continue from col 1; sof without pix_valid is ignored.
REQ-019 SHALL assert win_valid exactly 1 cycle after accepting pixel (r,c) when r>=2 and c>=2; win_col=c-1 and win_row=r-1 in that cycle.
REQ-020 SHALL hold win_valid low 1 cycle after any edge with pix_valid=0; window_out, win_col and win_row SHALL hold their previous values during stalls.
REQ-021 SHALL never produce a window spanning two lines; windows for c<2 or r<2 are suppressed, giving (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-022 SHALL pulse frame_done 1 cycle after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1), in the same cycle as that pixel's win_valid.
REQ-023 SHALL sustain 1 pixel per clock with no bubbles; throughput SHALL equal input rate.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, set col=0, row=0, win_valid=0, frame_done=0, window_out=0, win_col=0 and win_row=0.
REQ-025 SHALL leave line-buffer contents unreset; stale contents SHALL never reach a valid window (REQ-021 guarantees this).
REQ-026 SHALL, on reset mid-frame, discard the partial frame; the next accepted pixel is (0,0) with or without sof.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4; pixel (r,c) value = 16'h0r0c)
REQ-027 SHALL pass this test: stream 16 pixels back-to-back from sof -> first win_valid 1 cycle after pixel (2,2), window_out elements 0..8 = 0000,0001,0002,0100,0101,0102,0200,0201,0202, win_col=1, win_row=1; exactly 4 windows in total; frame_done coincides with the 4th window.
REQ-028 SHALL pass this test: same frame with pix_valid=0 for 3 cycles between pixels (2,2) and (2,3) -> win_valid low for the 3 stall cycles, outputs held; second window = 0001,0002,0003,0101,0102,0103,0201,0202,0203.
REQ-029 SHALL pass this test: 16'hF800 for rows 0-1 and 16'h0000 for rows 2-3 -> window (1,1) elements 0..5 = F800 and 6..8 = 0000; window (2,1) elements 0..2 = F800 and 3..8 = 0000.
REQ-030 SHALL pass this test: sof reasserted at pixel (2,1), then a full frame -> no window from the aborted frame after the restart; 4 windows with coordinates (1,1),(1,2),(2,1),(2,2).
REQ-031 SHALL pass this test: rst_n=0 for 1 cycle after pixel (2,2) is accepted -> next cycle win_valid=0 and all outputs 0; a following 16-pixel frame without sof yields the same 4 windows as REQ-027.
REQ-032 SHALL pass this test: two frames back-to-back, sof only on the first -> 8 windows and 2 frame_done pulses, separated by 16 cycles.

Source files
------------

// File: rtl/sobel_window_buffer.sv
// 3x3 neighbourhood generator for a raster RGB565 stream: two line buffers feed
// a left-shifting register window, emitting one window per interior pixel.
module sobel_window_buffer #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   pix_in,
    input  logic                          pix_valid,
    input  logic                          sof,
    output logic [143:0]                  window_out,
    output logic                          win_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic                          frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic [15:0]      lb1 [IMG_WIDTH];
    logic [15:0]      lb2 [IMG_WIDTH];
    logic [15:0]      lb1_rd, lb2_rd;
    logic [8:0][15:0] win_q, win_d;
    logic             win_valid_q, win_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [CW-1:0]    win_col_q, win_col_d;
    logic [RW-1:0]    win_row_q, win_row_d;
    logic             in_win;

    always_comb begin
        // sof forces the accepted pixel to (0,0); without pix_valid nothing moves anyway
        cur_col      = sof ? '0 : col_q;
        cur_row      = sof ? '0 : row_q;
        lb1_rd       = lb1[cur_col];
        lb2_rd       = lb2[cur_col];
        in_win       = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_col_d    = win_col_q;
        win_row_d    = win_row_q;
        win_valid_d  = pix_valid && in_win;
        frame_done_d = pix_valid && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        if (pix_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            // element 8 = newest pixel, right column = {lb2, lb1, pix_in} top to bottom
            win_d = {pix_in, win_q[8:7], lb1_rd, win_q[5:4], lb2_rd, win_q[2:1]};
            if (in_win) begin
                win_col_d = cur_col - CW'(1);
                win_row_d = cur_row - RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
        end
    end

    // Line buffers stay unreset; rows 0-1 of every frame overwrite them before use
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[cur_col] <= pix_in;
            lb2[cur_col] <= lb1_rd;
        end
    end

    assign window_out = win_q;
    assign win_valid  = win_valid_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_window_buffer.sv
// Bench for sobel_window_buffer on a 4x4 image, checked against a frame-store model.
module tb_sobel_window_buffer;
    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  pix_in = '0;
    logic         pix_valid = 1'b0;
    logic         sof = 1'b0;
    logic [143:0] window_out;
    logic         win_valid;
    logic [1:0]   win_col;
    logic [1:0]   win_row;
    logic         frame_done;

    sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .window_out(window_out), .win_valid(win_valid), .win_col(win_col),
        .win_row(win_row), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: remembers every pixel by image position, windows are read from it
    logic [15:0]  img [H][W];
    int           mr = 0, mc = 0;
    logic         exp_v = 1'b0, exp_fd = 1'b0;
    logic [143:0] exp_win = '0;
    int           exp_col = 0, exp_row = 0;

    function automatic logic [15:0] pv(input int r, input int c);
        return {8'(r), 8'(c)};
    endfunction

    task automatic model_reset();
        mr = 0; mc = 0; exp_v = 1'b0; exp_fd = 1'b0;
    endtask

    task automatic step(input logic v, input logic s, input logic [15:0] p);
        pix_valid = v; sof = s; pix_in = p;
        @(posedge clk);
        #1;
        exp_v = 1'b0; exp_fd = 1'b0;
        if (v) begin
            if (s) begin mr = 0; mc = 0; end
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                exp_v = 1'b1; exp_col = mc - 1; exp_row = mr - 1;
                for (int k = 0; k < 9; k++) exp_win[16*k +: 16] = img[mr-2+k/3][mc-2+k%3];
            end
            exp_fd = (mr == H-1) && (mc == W-1);
            if (mc == W-1) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
            else mc = mc + 1;
        end
        pix_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        model_reset();
        n_tests++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || window_out !== '0 || win_col !== 2'd0 || win_row !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: got v=%b fd=%b c=%0d r=%0d win=%h, want all zero", win_valid, frame_done, win_col, win_row, window_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int nw;
        nw = 0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
            step(1'b1, (r == 0 && c == 0), pv(r, c));
            if (win_valid === 1'b1) nw++;
            n_tests++;
            if (win_valid !== exp_v || frame_done !== exp_fd ||
                (exp_v && (window_out !== exp_win || win_col !== 2'(exp_col) || win_row !== 2'(exp_row)))) begin
                n_fail++;
                $display("FAIL basic (%0d,%0d): got v=%b fd=%b c=%0d r=%0d win=%h, want v=%b fd=%b c=%0d r=%0d win=%h",
                         r, c, win_valid, frame_done, win_col, win_row, window_out, exp_v, exp_fd, exp_col, exp_row, exp_win);
            end
            if (r == 2 && c == 2) begin
                n_tests++;
                if (window_out !== {16'h0202, 16'h0201, 16'h0200, 16'h0102, 16'h0101, 16'h0100, 16'h0002, 16'h0001, 16'h0000}) begin
                    n_fail++;
                    $display("FAIL basic_first_window: got %h", window_out);
                end
            end
            if (frame_done === 1'b1) begin
                n_tests++;
                if (nw !== 4 || win_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_frame_done: got windows=%0d v=%b, want windows=4 v=1", nw, win_valid);
                end
            end
        end
        n_tests++;
        if (nw !== 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d windows, want 4", nw);
        end
    endtask

    task automatic test_stall();
        logic [143:0] held;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
            step(1'b1, (r == 0 && c == 0), pv(r, c));
            n_tests++;
            if (win_valid !== exp_v || frame_done !== exp_fd ||
                (exp_v && (window_out !== exp_win || win_col !== 2'(exp_col) || win_row !== 2'(exp_row)))) begin
                n_fail++;
                $display("FAIL stall (%0d,%0d): got v=%b fd=%b c=%0d r=%0d win=%h, want v=%b fd=%b c=%0d r=%0d win=%h",
                         r, c, win_valid, frame_done, win_col, win_row, window_out, exp_v, exp_fd, exp_col, exp_row, exp_win);
            end
            if (r == 2 && c == 2) begin
                held = exp_win;
                for (int s = 0; s < 3; s++) begin
                    step(1'b0, 1'b0, 16'hDEAD);
                    n_tests++;
                    if (win_valid !== 1'b0 || window_out !== held || win_col !== 2'd1 || win_row !== 2'd1) begin
                        n_fail++;
                        $display("FAIL stall_hold cycle%0d: got v=%b c=%0d r=%0d win=%h, want v=0 c=1 r=1 win=%h",
                                 s, win_valid, win_col, win_row, window_out, held);
                    end
                end
            end
            if (r == 2 && c == 3) begin
                n_tests++;
                if (window_out !== {16'h0203, 16'h0202, 16'h0201, 16'h0103, 16'h0102, 16'h0101, 16'h0003, 16'h0002, 16'h0001}) begin
                    n_fail++;
                    $display("FAIL stall_second_window: got %h", window_out);
                end
            end
        end
    endtask

    task automatic test_color();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
            step(1'b1, (r == 0 && c == 0), (r < 2) ? 16'hF800 : 16'h0000);
            n_tests++;
            if (win_valid !== exp_v || (exp_v && window_out !== exp_win)) begin
                n_fail++;
                $display("FAIL color (%0d,%0d): got v=%b win=%h, want v=%b win=%h", r, c, win_valid, window_out, exp_v, exp_win);
            end
            if (r == 2 && c == 2) begin
                n_tests++;
                if (window_out !== {{3{16'h0000}}, {6{16'hF800}}}) begin
                    n_fail++;
                    $display("FAIL color_win11: got %h", window_out);
                end
            end
            if (r == 3 && c == 2) begin
                n_tests++;
                if (window_out !== {{6{16'h0000}}, {3{16'hF800}}}) begin
                    n_fail++;
                    $display("FAIL color_win21: got %h", window_out);
                end
            end
        end
    endtask

    task automatic test_sof_restart();
        int nw;
        int want_r [4] = '{1, 1, 2, 2};
        int want_c [4] = '{1, 2, 1, 2};
        for (int i = 0; i < 9; i++) step(1'b1, (i == 0), pv(i / W, i % W));
        nw = 0;
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, (i == 0), pv(i / W, i % W));
            n_tests++;
            if (win_valid !== exp_v || frame_done !== exp_fd || (exp_v && window_out !== exp_win)) begin
                n_fail++;
                $display("FAIL sof_restart px%0d: got v=%b fd=%b win=%h, want v=%b fd=%b win=%h",
                         i, win_valid, frame_done, window_out, exp_v, exp_fd, exp_win);
            end
            if (win_valid === 1'b1) begin
                n_tests++;
                if (nw > 3 || win_row !== 2'(want_r[nw & 3]) || win_col !== 2'(want_c[nw & 3])) begin
                    n_fail++;
                    $display("FAIL sof_restart_coord #%0d: got (%0d,%0d)", nw, win_row, win_col);
                end
                nw++;
            end
        end
        n_tests++;
        if (nw !== 4) begin
            n_fail++;
            $display("FAIL sof_restart_count: got %0d windows, want 4", nw);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 11; i++) step(1'b1, (i == 0), pv(i / W, i % W));
        rst_n = 1'b0;
        step(1'b0, 1'b0, '0);
        model_reset();
        n_tests++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || window_out !== '0 || win_col !== 2'd0 || win_row !== 2'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got v=%b fd=%b c=%0d r=%0d win=%h, want all zero", win_valid, frame_done, win_col, win_row, window_out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < W*H; i++) begin
            step(1'b1, 1'b0, pv(i / W, i % W));
            n_tests++;
            if (win_valid !== exp_v || frame_done !== exp_fd ||
                (exp_v && (window_out !== exp_win || win_col !== 2'(exp_col) || win_row !== 2'(exp_row)))) begin
                n_fail++;
                $display("FAIL after_reset px%0d: got v=%b fd=%b c=%0d r=%0d win=%h, want v=%b fd=%b c=%0d r=%0d win=%h",
                         i, win_valid, frame_done, win_col, win_row, window_out, exp_v, exp_fd, exp_col, exp_row, exp_win);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nw, nfd, fd0, fd1;
        nw = 0; nfd = 0; fd0 = -1; fd1 = -1;
        for (int i = 0; i < 2*W*H; i++) begin
            step(1'b1, (i == 0), 16'(i * 37 + 5));
            if (win_valid === 1'b1) nw++;
            if (frame_done === 1'b1) begin
                if (nfd == 0) fd0 = i; else fd1 = i;
                nfd++;
            end
            n_tests++;
            if (win_valid !== exp_v || frame_done !== exp_fd || (exp_v && window_out !== exp_win)) begin
                n_fail++;
                $display("FAIL b2b px%0d: got v=%b fd=%b win=%h, want v=%b fd=%b win=%h",
                         i, win_valid, frame_done, window_out, exp_v, exp_fd, exp_win);
            end
        end
        n_tests++;
        if (nw !== 8 || nfd !== 2 || fd1 - fd0 !== 16) begin
            n_fail++;
            $display("FAIL b2b_totals: got windows=%0d pulses=%0d gap=%0d, want 8 2 16", nw, nfd, fd1 - fd0);
        end
    endtask

    task automatic test_random();
        logic v, s;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            s = (i == 0) || ($urandom_range(0, 29) == 0);
            step(v, s, 16'($urandom));
            n_tests++;
            if (win_valid !== exp_v || frame_done !== exp_fd ||
                (exp_v && (window_out !== exp_win || win_col !== 2'(exp_col) || win_row !== 2'(exp_row)))) begin
                n_fail++;
                $display("FAIL random cyc%0d: got v=%b fd=%b c=%0d r=%0d win=%h, want v=%b fd=%b c=%0d r=%0d win=%h",
                         i, win_valid, frame_done, win_col, win_row, window_out, exp_v, exp_fd, exp_col, exp_row, exp_win);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_color();
        test_sof_restart();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
